// File: rtl/hex_display_scan_pkg.sv
// Shared types, 7-segment font table and nibble-to-segment helper for the
// hex display scanner.
package hex_display_pkg;

  typedef logic [6:0] seg7_t;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  // Active-high segment patterns {g,f,e,d,c,b,a} for 0..F
  localparam seg7_t HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg7_t hex_to_seg(input logic [3:0] nibble);
    return HEX_FONT[nibble];
  endfunction

endpackage

// File: rtl/hex_display_scan_if.sv
// CPU-side write port and display pin bundle for the hex display scanner.
interface hex_display_scan_if #(
  parameter int NUM_DIGITS = 8
);
  import hex_display_pkg::*;

  logic [31:0]           value;
  logic                  value_we;
  seg7_t                 seg;
  logic                  dp;
  logic [NUM_DIGITS-1:0] an;
  logic                  frame_start;

  modport master (output value, value_we, input seg, dp, an, frame_start);
  modport slave  (input value, value_we, output seg, dp, an, frame_start);
endinterface

// File: rtl/hex_display_scan_decode.sv
// Combinational hex nibble to active-high 7-segment pattern decoder.
module hex7seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/hex_display_scan.sv
// Double-buffered, prescaled multiplexed hex display driver with per-slot blanking.
// Optional leading-zero suppression when HEX_LZ_BLANK_EN is defined.
module hex_display_scan
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  hex_display_scan_if.slave bus
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_POL    = {NUM_DIGITS{ACTIVE_LOW}};
  localparam seg7_t                 SEG_POL   = {7{ACTIVE_LOW}};

  logic [CNT_W-1:0]      cnt_r, cnt_nx_s;
  logic [IDX_W-1:0]      digit_idx_r, digit_idx_nx_s;
  logic                  slot_wrap_s, frame_wrap_s;
  scan_state_t           state_r, state_nx_s;
  logic [31:0]           shadow_r, display_reg_r;
  logic                  pending_r;
  logic [3:0]            nibble_s;
  seg7_t                 font_s, seg_act_s, seg_r;
  logic [NUM_DIGITS-1:0] digit_sel_s, digit_vis_s, an_act_s, an_r;
  logic                  dp_r, frame_start_r;
`ifdef HEX_LZ_BLANK_EN
  logic                  nz_above_s;
`endif

  // Slot counter and digit index successor values
  always_comb begin
    slot_wrap_s  = (cnt_r == CNT_LAST);
    frame_wrap_s = slot_wrap_s && (digit_idx_r == IDX_LAST);
    if (slot_wrap_s) begin
      cnt_nx_s = {CNT_W{1'b0}};
    end else begin
      cnt_nx_s = cnt_r + CNT_W'(1'b1);
    end
    if (frame_wrap_s) begin
      digit_idx_nx_s = {IDX_W{1'b0}};
    end else if (slot_wrap_s) begin
      digit_idx_nx_s = digit_idx_r + IDX_W'(1'b1);
    end else begin
      digit_idx_nx_s = digit_idx_r;
    end
  end

  // Scan state follows the counter so state_r always matches cnt_r
  always_comb begin
    if (cnt_nx_s < BLANK_END) begin
      state_nx_s = ST_BLANK;
    end else begin
      state_nx_s = ST_DRIVE;
    end
  end

  // Scan position and state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r       <= {CNT_W{1'b0}};
      digit_idx_r <= {IDX_W{1'b0}};
      state_r     <= ST_BLANK;
    end else begin
      cnt_r       <= cnt_nx_s;
      digit_idx_r <= digit_idx_nx_s;
      state_r     <= state_nx_s;
    end
  end

  // Shadow capture; the frame boundary promotes the pre-write shadow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_r      <= 32'h0000_0000;
      display_reg_r <= 32'h0000_0000;
      pending_r     <= 1'b0;
    end else begin
      if (bus.value_we) begin
        shadow_r <= bus.value;
      end else begin
        shadow_r <= shadow_r;
      end
      if (frame_wrap_s && pending_r) begin
        display_reg_r <= shadow_r;
      end else begin
        display_reg_r <= display_reg_r;
      end
      if (bus.value_we) begin
        pending_r <= 1'b1;
      end else if (frame_wrap_s) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  // Digit select, nibble mux and per-digit visibility
  always_comb begin
    nibble_s    = 4'h0;
    digit_sel_s = {NUM_DIGITS{1'b0}};
    digit_vis_s = {NUM_DIGITS{1'b1}};
`ifdef HEX_LZ_BLANK_EN
    nz_above_s  = 1'b0;
`endif
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (digit_idx_r == IDX_W'(i)) begin
        digit_sel_s[i] = 1'b1;
        nibble_s       = display_reg_r[4*i +: 4];
      end else begin
        digit_sel_s[i] = 1'b0;
      end
`ifdef HEX_LZ_BLANK_EN
      // Digits above the most-significant nonzero nibble stay dark; digit 0 never does
      nz_above_s     = nz_above_s | (display_reg_r[4*i +: 4] != 4'h0);
      digit_vis_s[i] = nz_above_s || (i == 0);
`else
      digit_vis_s[i] = 1'b1;
`endif
    end
  end

  hex7seg_decode u_decode (
    .nibble (nibble_s),
    .seg    (font_s)
  );

  // Active-high pin intent for the current state
  always_comb begin
    an_act_s  = {NUM_DIGITS{1'b0}};
    seg_act_s = 7'h00;
    case (state_r)
      ST_BLANK: begin
        an_act_s  = {NUM_DIGITS{1'b0}};
        seg_act_s = 7'h00;
      end
      ST_DRIVE: begin
        an_act_s  = digit_sel_s & digit_vis_s;
        seg_act_s = font_s;
      end
      default: begin
        an_act_s  = {NUM_DIGITS{1'b0}};
        seg_act_s = 7'h00;
      end
    endcase
  end

  // Registered pins with polarity applied
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_r          <= AN_POL;
      seg_r         <= SEG_POL;
      dp_r          <= ACTIVE_LOW;
      frame_start_r <= 1'b0;
    end else begin
      an_r          <= an_act_s ^ AN_POL;
      seg_r         <= seg_act_s ^ SEG_POL;
      dp_r          <= ACTIVE_LOW;
      frame_start_r <= frame_wrap_s;
    end
  end

  assign bus.an          = an_r;
  assign bus.seg         = seg_r;
  assign bus.dp          = dp_r;
  assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_hex_display_scan.sv
// Self-checking bench for hex_display_scan: per-cycle frame-arithmetic model plus
// directed literal checks. NUM_DIGITS=8, CLK_DIV=4, BLANK_CYCLES=1, ACTIVE_LOW=1.
module tb_hex_display_scan;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  hex_display_scan_if #(.NUM_DIGITS(8)) bus ();

  hex_display_scan #(
    .NUM_DIGITS   (8),
    .CLK_DIV      (4),
    .BLANK_CYCLES (1),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] font [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: k = edges since reset release; pins after an edge show the scan
  // position and displayed word as they stood before that edge.
  int          k;
  logic [31:0] m_shadow, m_disp, sh;
  logic        m_pend;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_fs;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        k = 0; m_shadow = 32'h0; m_disp = 32'h0; m_pend = 1'b0;
        e_an = 8'hFF; e_seg = 7'h7F; e_fs = 1'b0;
      end else begin
        if ((k % 4) < 1) begin
          e_an = 8'hFF; e_seg = 7'h7F;
        end else begin
          sh    = m_disp >> (4 * ((k / 4) % 8));
          e_seg = ~font[sh[3:0]];
          e_an  = ~(8'h01 << ((k / 4) % 8));
`ifdef HEX_LZ_BLANK_EN
          if (((k / 4) % 8) != 0 && sh == 32'h0) e_an = 8'hFF;
`endif
        end
        k++;
        e_fs = ((k % 32) == 0);
        if (e_fs && m_pend) begin m_disp = m_shadow; m_pend = 1'b0; end
        if (bus.value_we) begin m_shadow = bus.value; m_pend = 1'b1; end
      end
      #1;
      chk("model_an", {24'h0, bus.an}, {24'h0, e_an});
      chk("model_seg", {25'h0, bus.seg}, {25'h0, e_seg});
      chk("model_dp", {31'h0, bus.dp}, 32'h1);
      chk("model_fs", {31'h0, bus.frame_start}, {31'h0, e_fs});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_val(input logic [31:0] v);
    bus.value = v; bus.value_we = 1'b1;
    @(negedge clk);
    bus.value_we = 1'b0;
  endtask

  task automatic wait_fs(output int at);
    at = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.frame_start === 1'b1) begin at = cyc; break; end
    end
    if (at < 0) begin
      checks++;
      $display("FAIL fs_timeout: got no frame_start expected one within 40 cycles");
    end
  endtask

  int t0, t1, c0, n_blank, n_one;
  logic [7:0] an_low;

  initial begin
    rst_n = 1'b0; bus.value = 32'h0; bus.value_we = 1'b0;
    tick(3);
    chk("rst_an", {24'h0, bus.an}, 32'hFF);
    chk("rst_seg", {25'h0, bus.seg}, 32'h7F);
    chk("rst_fs", {31'h0, bus.frame_start}, 32'h0);
    rst_n = 1'b1;
    c0 = cyc;
    wait_fs(t0);
    chk("first_fs", t0 - c0, 32);
    wait_fs(t1);
    chk("fs_period", t1 - t0, 32);

    // Mid-frame write is not shown until the next frame
    tick(5);
    write_val(32'h0123_ABCD);
    chk("pre_frame_an", {24'h0, bus.an}, 32'hFD);
    chk("pre_frame_seg", {25'h0, bus.seg}, 32'h40);
    wait_fs(t0);
    tick(2);
    chk("d0_an", {24'h0, bus.an}, 32'hFE);
    chk("d0_seg", {25'h0, bus.seg}, 32'h21);
    tick(28);
`ifdef HEX_LZ_BLANK_EN
    chk("d7_an", {24'h0, bus.an}, 32'hFF);
`else
    chk("d7_an", {24'h0, bus.an}, 32'h7F);
`endif
    chk("d7_seg", {25'h0, bus.seg}, 32'h40);

    // One whole frame: blank first cycle of each slot, one-hot otherwise
    wait_fs(t0);
    n_blank = 0; n_one = 0;
    for (int i = 0; i < 32; i++) begin
      tick(1);
      if (bus.an == 8'hFF) n_blank++;
      if ($countones(~bus.an) == 1) n_one++;
    end
`ifdef HEX_LZ_BLANK_EN
    chk("blank_cycles", n_blank, 11);
    chk("onehot_cycles", n_one, 21);
`else
    chk("blank_cycles", n_blank, 8);
    chk("onehot_cycles", n_one, 24);
`endif

    // Last write wins
    write_val(32'h1111_1111);
    tick(3);
    write_val(32'h2222_2222);
    wait_fs(t0);
    tick(2);
    chk("lww_an", {24'h0, bus.an}, 32'hFE);
    chk("lww_seg", {25'h0, bus.seg}, 32'h24);

    // Write landing on the boundary edge is deferred one frame
    wait_fs(t0);
    write_val(32'h0000_0005);
    tick(30);
    write_val(32'hFFFF_FFFF);
    chk("coll_fs", {31'h0, bus.frame_start}, 32'h1);
    tick(2);
    chk("coll_d0_an", {24'h0, bus.an}, 32'hFE);
    chk("coll_d0_seg", {25'h0, bus.seg}, 32'h12);
    tick(4);
`ifdef HEX_LZ_BLANK_EN
    chk("coll_d1_an", {24'h0, bus.an}, 32'hFF);
`else
    chk("coll_d1_an", {24'h0, bus.an}, 32'hFD);
`endif
    chk("coll_d1_seg", {25'h0, bus.seg}, 32'h40);
    tick(28);
    chk("next_d0_seg", {25'h0, bus.seg}, 32'h0E);

    // Reset mid-scan drops display and pending data
    tick(3);
    write_val(32'h0000_0777);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_an", {24'h0, bus.an}, 32'hFF);
    chk("mid_rst_seg", {25'h0, bus.seg}, 32'h7F);
    chk("mid_rst_fs", {31'h0, bus.frame_start}, 32'h0);
    rst_n = 1'b1;
    c0 = cyc;
    tick(2);
    chk("restart_an", {24'h0, bus.an}, 32'hFE);
    chk("restart_seg", {25'h0, bus.seg}, 32'h40);
    wait_fs(t0);
    chk("restart_fs", t0 - c0, 32);

    // 0xA5: only the two low digits carry information
    write_val(32'h0000_00A5);
    wait_fs(t0);
    an_low = 8'h00;
    for (int i = 1; i <= 32; i++) begin
      tick(1);
      an_low = an_low | ~bus.an;
      if (i == 2) chk("a5_d0_seg", {25'h0, bus.seg}, 32'h12);
      if (i == 6) begin
        chk("a5_d1_an", {24'h0, bus.an}, 32'hFD);
        chk("a5_d1_seg", {25'h0, bus.seg}, 32'h08);
      end
    end
`ifdef HEX_LZ_BLANK_EN
    chk("a5_an_low", {24'h0, an_low}, 32'h03);
`else
    chk("a5_an_low", {24'h0, an_low}, 32'hFF);
`endif

    tick(1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
